// File: rtl/rf_access_ctrl.sv
// Read/write arbiter in front of a single-port-per-cycle register file, with write buffer and read forwarding.
// Latency: read response 2 cycles after acceptance; buffered writes drain in cycles without a read.
// Backpressure: both request readies drop while the write buffer is full; the next cycle then drains.
module rf_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              rd_req_valid,
    output logic                              rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]             rd_addr1,
    input  logic [ADDR_WIDTH-1:0]             rd_addr2,
    output logic                              rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]             rd_data1,
    output logic [DATA_WIDTH-1:0]             rd_data2,
    input  logic                              wr_req_valid,
    output logic                              wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              rf_read,
    output logic                              rf_write,
    output logic [ADDR_WIDTH-1:0]             rf_addr_r1,
    output logic [ADDR_WIDTH-1:0]             rf_addr_r2,
    output logic [ADDR_WIDTH-1:0]             rf_addr_w,
    output logic [DATA_WIDTH-1:0]             rf_data_w,
    input  logic [DATA_WIDTH-1:0]             rf_data_r1,
    input  logic [DATA_WIDTH-1:0]             rf_data_r2,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count
);
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_nxt;
    logic                  full, rd_acc, wr_acc, pop;
    logic                  fwd1_hit, fwd2_hit;
    logic [DATA_WIDTH-1:0] fwd1_dat, fwd2_dat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (count == CNT_W'(WBUF_DEPTH));
    assign rd_req_ready = !full;
    assign wr_req_ready = !full;
    assign rd_acc       = rd_req_valid && rd_req_ready;
    assign wr_acc       = wr_req_valid && wr_req_ready;
    assign pop          = (state == WR);
    assign count_nxt    = count + CNT_W'(wr_acc) - CNT_W'(pop);

    assign rf_read      = (state == RD);
    assign rf_write     = (state == WR);
    assign rf_addr_w    = rf_write ? wb_addr[rd_ptr] : '0;
    assign rf_data_w    = rf_write ? wb_data[rd_ptr] : '0;
    assign wbuf_count   = count;

    always_comb begin
        state_nxt = IDLE;
        if (rd_acc)
            state_nxt = RD;
        else if (count_nxt != '0)
            state_nxt = WR;
    end

    // Walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [PTR_W-1:0] slot;
        fwd1_hit = 1'b0;
        fwd2_hit = 1'b0;
        fwd1_dat = '0;
        fwd2_dat = '0;
        sum      = '0;
        slot     = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            sum = {1'b0, rd_ptr} + SUM_W'(i);
            if (sum >= SUM_W'(WBUF_DEPTH))
                sum = sum - SUM_W'(WBUF_DEPTH);
            slot = sum[PTR_W-1:0];
            if (CNT_W'(i) < count) begin
                if (wb_addr[slot] == rf_addr_r1) begin
                    fwd1_hit = 1'b1;
                    fwd1_dat = wb_data[slot];
                end
                if (wb_addr[slot] == rf_addr_r2) begin
                    fwd2_hit = 1'b1;
                    fwd2_dat = wb_data[slot];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_rsp_valid <= 1'b0;
            rd_data1     <= '0;
            rd_data2     <= '0;
            rf_addr_r1   <= '0;
            rf_addr_r2   <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            rd_rsp_valid <= rf_read;
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (rd_acc) begin
                rf_addr_r1 <= rd_addr1;
                rf_addr_r2 <= rd_addr2;
            end
            // A write pushed on this same edge is younger than the read and is not seen.
            if (rf_read) begin
                rd_data1 <= fwd1_hit ? fwd1_dat : rf_data_r1;
                rd_data2 <= fwd2_hit ? fwd2_dat : rf_data_r2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            wb_addr[wr_ptr] <= wr_addr;
            wb_data[wr_ptr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 32x32 register file attached.
module tb_rf_access_ctrl;
    logic        CLK;
    logic        RST;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_rsp_valid;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rf_read;
    logic        rf_write;
    logic [4:0]  rf_addr_r1;
    logic [4:0]  rf_addr_r2;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w;
    logic [31:0] rf_data_r1;
    logic [31:0] rf_data_r2;
    logic [2:0]  wbuf_count;

    int total = 0;
    int bad   = 0;

    rf_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WBUF_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_rsp_valid(rd_rsp_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_read(rf_read), .rf_write(rf_write),
        .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
        .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2),
        .wbuf_count(wbuf_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file model: initial contents 0x1000_0000 + index.
    logic [31:0] rf_mem [32];
    bit          mem_init;
    logic [4:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          both_cnt = 0;

    assign rf_data_r1 = rf_read ? rf_mem[rf_addr_r1] : 32'hBAD0_BAD0;
    assign rf_data_r2 = rf_read ? rf_mem[rf_addr_r2] : 32'hBAD0_BAD0;

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
            mem_init = 1'b1;
        end
        if (rf_read && rf_write) both_cnt++;
        if (rf_write) begin
            rf_mem[rf_addr_w] = rf_data_w;
            log_addr.push_back(rf_addr_w);
            log_data.push_back(rf_data_w);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int mark;
        int idx;
        RST = 1'b0;
        rd_req_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        wr_req_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();

        chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
        chk("rst_data1", rd_data1, 32'd0);
        chk("rst_data2", rd_data2, 32'd0);
        chk("rst_rf_read", 32'(rf_read), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_count", 32'(wbuf_count), 32'd0);
        chk("rst_addr_r1", 32'(rf_addr_r1), 32'd0);
        chk("rst_addr_w", 32'(rf_addr_w), 32'd0);
        chk("rst_data_w", rf_data_w, 32'd0);
        chk("rst_rd_ready", 32'(rd_req_ready), 32'd1);
        RST = 1'b1;
        repeat (2) tick();

        // Reset in the middle of a WR cycle with three buffered entries.
        wr_req_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA_0001;
        rd_req_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        tick();
        wr_addr = 5'd11; wr_data = 32'hAAAA_0002;
        tick();
        wr_addr = 5'd12; wr_data = 32'hAAAA_0003;
        tick();
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        tick();
        chk("t1_pre_write", 32'(rf_write), 32'd1);
        chk("t1_pre_count", 32'(wbuf_count), 32'd3);
        chk("t1_pre_addr_w", 32'(rf_addr_w), 32'd10);
        #2 RST = 1'b0;
        #1;
        chk("t1_rst_count", 32'(wbuf_count), 32'd0);
        chk("t1_rst_write", 32'(rf_write), 32'd0);
        tick();
        RST = 1'b1;
        repeat (5) tick();
        chk("t1_no_rf_writes", 32'(log_addr.size()), 32'd0);
        chk("t1_idle_count", 32'(wbuf_count), 32'd0);

        // Write r5, let it drain, then read (r5, r0).
        wr_req_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_req_valid = 1'b0;
        repeat (4) tick();
        rd_req_valid = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd0;
        tick();
        rd_req_valid = 1'b0;
        chk("t2_rf_read", 32'(rf_read), 32'd1);
        chk("t2_rsp_early", 32'(rd_rsp_valid), 32'd0);
        tick();
        chk("t2_rsp_valid", 32'(rd_rsp_valid), 32'd1);
        chk("t2_data1", rd_data1, 32'hDEAD_BEEF);
        chk("t2_data2", rd_data2, 32'h1000_0000);
        tick();
        chk("t2_rsp_pulse", 32'(rd_rsp_valid), 32'd0);
        chk("t2_data1_hold", rd_data1, 32'hDEAD_BEEF);

        // Forwarding: second write to r7 accepted with the read.
        wr_req_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
        tick();
        wr_data = 32'h2222_2222;
        rd_req_valid = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
        tick();
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        tick();
        chk("t3_rsp_valid", 32'(rd_rsp_valid), 32'd1);
        chk("t3_data1", rd_data1, 32'h2222_2222);
        chk("t3_data2", rd_data2, 32'h2222_2222);
        repeat (3) tick();
        chk("t3_drained", 32'(wbuf_count), 32'd0);

        // Fill the buffer while reads are requested every cycle.
        rd_req_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            wr_req_valid = 1'b1; wr_addr = 5'(20 + i); wr_data = 32'h4000_0000 + 32'(i);
            tick();
        end
        wr_req_valid = 1'b0;
        chk("t4_count_full", 32'(wbuf_count), 32'd4);
        chk("t4_rd_ready_full", 32'(rd_req_ready), 32'd0);
        chk("t4_wr_ready_full", 32'(wr_req_ready), 32'd0);
        chk("t4_last_read", 32'(rf_read), 32'd1);
        tick();
        chk("t4_stall_write", 32'(rf_write), 32'd1);
        chk("t4_stall_ready", 32'(rd_req_ready), 32'd0);
        tick();
        chk("t4_count_3", 32'(wbuf_count), 32'd3);
        chk("t4_ready_back", 32'(rd_req_ready), 32'd1);
        chk("t4_wr_ready_back", 32'(wr_req_ready), 32'd1);
        rd_req_valid = 1'b0;
        repeat (6) tick();
        chk("t4_drained", 32'(wbuf_count), 32'd0);

        // Ordering of drained writes r1..r8 with interleaved reads.
        mark = log_addr.size();
        for (int i = 1; i <= 8; i++) begin
            wr_req_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 16);
            rd_req_valid = (i % 2 == 0); rd_addr1 = 5'(i); rd_addr2 = 5'(i - 1);
            for (int k = 0; k < 20 && !wr_req_ready; k++) tick();
            chk("t5_wr_ready", 32'(wr_req_ready), 32'd1);
            tick();
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (10) tick();
        chk("t5_write_count", 32'(log_addr.size() - mark), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            idx = mark + i - 1;
            chk("t5_order_addr", (idx < log_addr.size()) ? 32'(log_addr[idx]) : 32'hFFFF_FFFF, 32'(i));
            chk("t5_order_data", (idx < log_data.size()) ? log_data[idx] : 32'hFFFF_FFFF, 32'(i * 16));
        end

        // A write accepted one edge after the read must not be visible to it.
        rd_req_valid = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        tick();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_00A5;
        tick();
        wr_req_valid = 1'b0;
        chk("t6_rsp_valid", 32'(rd_rsp_valid), 32'd1);
        chk("t6_data1_old", rd_data1, 32'h1000_0009);
        chk("t6_data2_old", rd_data2, 32'h1000_0009);
        repeat (3) tick();
        rd_req_valid = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd3;
        tick();
        rd_req_valid = 1'b0;
        tick();
        chk("t6_data1_new", rd_data1, 32'h0000_00A5);
        chk("t6_data2_r3", rd_data2, 32'h0000_0030);

        chk("never_read_and_write", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
